// File: rtl/error_ring_dispatcher.sv
// error_ring_dispatcher
//   Drains the error-report FIFO and writes each 64-bit record into a
//   software-visible ring in local memory through a single-request write
//   port. Tracks the hardware write index (WPTR) against the software read
//   index (RP), and raises a coalesced level interrupt either on a pending
//   threshold or when a non-empty ring has waited TIMEOUT cycles.
//
// Ports
//   CLK, RESET        clock (rising edge), async active-low reset
//   ENA               dispatch enable
//   BASE              ring base byte address (low 3 bits ignored)
//   THRESH            pending-count interrupt threshold (0 treated as 1)
//   RDPTR/RDPTR_WE    software read index and its load strobe
//   VALID/ECD/ERD     FIFO side: record present, record, pop (combinational)
//   MemACT/MemNEXT    memory write request / accepted
//   MemADDR/MemDATA   write byte address / data, stable while MemACT
//   WPTR/PENDING      hardware write index / records not yet consumed
//   INTR/INTR_ACK     level interrupt / clear
//   DROPCNT           saturating dropped-record count
//
// Build option
//   ERRDISP_DROP_EN   when defined, a record arriving while the ring is full
//                     is popped and discarded (counted in DROPCNT) instead of
//                     stalling the FIFO. Undefined: stall, DROPCNT = 0.
module error_ring_dispatcher #(
  parameter int ADDR_W    = 37,
  parameter int RING_LOG2 = 6,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ENA,
  input  logic [ADDR_W-1:0]    BASE,
  input  logic [RING_LOG2-1:0] THRESH,
  input  logic [RING_LOG2-1:0] RDPTR,
  input  logic                 RDPTR_WE,
  input  logic                 VALID,
  input  logic [63:0]          ECD,
  output logic                 ERD,
  output logic                 MemACT,
  input  logic                 MemNEXT,
  output logic [ADDR_W-1:0]    MemADDR,
  output logic [63:0]          MemDATA,
  output logic [RING_LOG2-1:0] WPTR,
  output logic [RING_LOG2-1:0] PENDING,
  output logic                 INTR,
  input  logic                 INTR_ACK,
  output logic [15:0]          DROPCNT
);

  localparam int SLOT_W = ADDR_W - 3;
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]        TLAST = TW'(TIMEOUT - 1);
  localparam logic [RING_LOG2-1:0] ONE   = RING_LOG2'(1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t               state_q, state_d;
  logic [RING_LOG2-1:0] wptr_q, wptr_d;
  logic [RING_LOG2-1:0] rp_q, rp_d;
  logic                 act_q, act_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [63:0]          data_q, data_d;
  logic                 intr_q, intr_d;
  logic [TW-1:0]        tmr_q, tmr_d;

  logic                 full, pop_ok, do_write, tmr_hit, intr_set;
  logic [RING_LOG2-1:0] pending, thr_eff;
  logic [SLOT_W-1:0]    slot;
  logic                 unused_ok;

  // Byte-address low bits are implied by 8-byte alignment.
  assign unused_ok = ^BASE[2:0];

  assign pending = wptr_q - rp_q;
  assign full    = (wptr_q + ONE) == rp_q;
  assign pop_ok  = (state_q == IDLE) && ENA && VALID;
  assign slot    = BASE[ADDR_W-1:3] + SLOT_W'(wptr_q);

`ifdef ERRDISP_DROP_EN
  logic [15:0] drop_q, drop_d;

  // Full ring: still pop, but discard instead of writing.
  assign ERD      = pop_ok;
  assign do_write = pop_ok && !full;

  always_comb begin
    drop_d = drop_q;
    if (pop_ok && full && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign DROPCNT = drop_q;
`else
  assign ERD      = pop_ok && !full;
  assign do_write = ERD;
  assign DROPCNT  = 16'h0;
`endif

  // Dispatch FSM: capture on pop, hold request until accepted.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    act_d   = act_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (do_write) begin
          data_d  = ECD;
          addr_d  = {slot, 3'b000};
          act_d   = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (MemNEXT) begin
          act_d   = 1'b0;
          wptr_d  = wptr_q + ONE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read index, timer and interrupt.
  assign thr_eff  = (THRESH == '0) ? ONE : THRESH;
  assign tmr_hit  = (tmr_q == TLAST);
  assign intr_set = (pending >= thr_eff) || ((pending != '0) && tmr_hit);

  always_comb begin
    rp_d = RDPTR_WE ? RDPTR : rp_q;

    // Saturate at the expiry value so an ACK that collides with expiry
    // does not lose the timeout; it re-fires on the next cycle.
    tmr_d = tmr_q;
    if ((pending == '0) || intr_q) tmr_d = '0;
    else if (!tmr_hit)             tmr_d = tmr_q + TW'(1);

    intr_d = INTR_ACK ? 1'b0 : (intr_q || intr_set);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rp_q    <= '0;
      act_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      intr_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rp_q    <= rp_d;
      act_q   <= act_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      intr_q  <= intr_d;
      tmr_q   <= tmr_d;
    end
  end

  assign MemACT  = act_q;
  assign MemADDR = addr_q;
  assign MemDATA = data_q;
  assign WPTR    = wptr_q;
  assign PENDING = pending;
  assign INTR    = intr_q;

endmodule

// File: tb/tb_error_ring_dispatcher.sv
module tb_error_ring_dispatcher;
  localparam int AW = 37;
  localparam int RL = 4;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RESET, ENA, RDPTR_WE, VALID, MemNEXT, INTR_ACK;
  logic [AW-1:0] BASE;
  logic [RL-1:0] THRESH, RDPTR;
  logic [63:0]   ECD;
  logic          ERD, MemACT, INTR;
  logic [AW-1:0] MemADDR;
  logic [63:0]   MemDATA;
  logic [RL-1:0] WPTR, PENDING;
  logic [15:0]   DROPCNT;

  error_ring_dispatcher #(.ADDR_W(AW), .RING_LOG2(RL), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .ENA(ENA), .BASE(BASE), .THRESH(THRESH),
    .RDPTR(RDPTR), .RDPTR_WE(RDPTR_WE), .VALID(VALID), .ECD(ECD), .ERD(ERD),
    .MemACT(MemACT), .MemNEXT(MemNEXT), .MemADDR(MemADDR), .MemDATA(MemDATA),
    .WPTR(WPTR), .PENDING(PENDING), .INTR(INTR), .INTR_ACK(INTR_ACK),
    .DROPCNT(DROPCNT)
  );

  always #5 CLK = ~CLK;

  int nchk = 0, nerr = 0;
  logic [63:0]   fifo[$];
  logic [AW-1:0] waddr[$];
  logic [63:0]   wdata[$];
  int erd_cnt, act_cnt, viol, tp, ti;

  task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task upd();
    VALID = (fifo.size() != 0);
    ECD   = VALID ? fifo[0] : 64'h0;
  endtask

  task clr();
    fifo.delete(); waddr.delete(); wdata.delete();
    erd_cnt = 0; act_cnt = 0; viol = 0;
    upd();
  endtask

  // One clock: observe pre-edge outputs, cross the edge, model the FIFO pop.
  task tick();
    logic pop;
    #1;
    pop = ERD;
    if (ERD) erd_cnt++;
    if (MemACT) act_cnt++;
    if (ERD && MemACT) viol++;
    if (MemACT && MemNEXT) begin
      waddr.push_back(MemADDR);
      wdata.push_back(MemDATA);
    end
    @(posedge CLK); #1;
    if (pop && fifo.size() != 0) fifo.delete(0);
    upd();
  endtask

  task run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task do_reset();
    @(posedge CLK); #1;
    RESET = 1'b0;
    clr();
    #10;
    RESET = 1'b1;
  endtask

  // Cycle index where PENDING first equals want, and where INTR first rises.
  task measure(input logic [RL-1:0] want, input int n);
    tp = -1; ti = -1;
    for (int c = 0; c < n; c++) begin
      tick();
      if (PENDING == want && tp < 0) tp = c;
      if (INTR && ti < 0) ti = c;
    end
  endtask

  initial begin
    RESET = 1'b0; ENA = 1'b0; BASE = '0; THRESH = '0; RDPTR = '0;
    RDPTR_WE = 1'b0; MemNEXT = 1'b0; INTR_ACK = 1'b0;
    clr();
    #12 RESET = 1'b1;
    #1;
    chk("rst_erd", ERD, 0);       chk("rst_act", MemACT, 0);
    chk("rst_addr", MemADDR, 0);  chk("rst_data", MemDATA, 0);
    chk("rst_wptr", WPTR, 0);     chk("rst_pend", PENDING, 0);
    chk("rst_intr", INTR, 0);     chk("rst_drop", DROPCNT, 0);

    // Single record
    do_reset();
    BASE = 37'h1000; ENA = 1'b1; THRESH = 4'd15; MemNEXT = 1'b1;
    fifo.push_back(64'hA5A5_0000_1234_5678); upd();
    run(6);
    chk("t1_erd_pulses", erd_cnt, 1);
    chk("t1_act_cycles", act_cnt, 1);
    chk("t1_addr", waddr[0], 37'h1000);
    chk("t1_data", wdata[0], 64'hA5A5_0000_1234_5678);
    chk("t1_wptr", WPTR, 1);
    chk("t1_pend", PENDING, 1);

    // Back-to-back three records, NEXT held high
    clr();
    fifo.push_back(64'h11); fifo.push_back(64'h22); fifo.push_back(64'h33); upd();
    run(10);
    chk("t2_writes", waddr.size(), 3);
    chk("t2_addr0", waddr[0], 37'h1008);
    chk("t2_addr1", waddr[1], 37'h1010);
    chk("t2_addr2", waddr[2], 37'h1018);
    chk("t2_data1", wdata[1], 64'h22);
    chk("t2_act_cycles", act_cnt, 3);
    chk("t2_erd_vs_act", viol, 0);
    chk("t2_wptr", WPTR, 4);

    // Request held while not accepted; reset aborts it
    clr(); MemNEXT = 1'b0;
    fifo.push_back(64'h44); upd();
    run(3);
    chk("hold_act", MemACT, 1);
    chk("hold_addr", MemADDR, 37'h1020);
    tick();
    chk("hold_act2", MemACT, 1);
    chk("hold_data", MemDATA, 64'h44);
    chk("hold_erd", erd_cnt, 1);
    RESET = 1'b0; #1;
    chk("abort_act", MemACT, 0);
    chk("abort_wptr", WPTR, 0);
    chk("abort_addr", MemADDR, 0);
    #9 RESET = 1'b1;

    // Fill to full, then advance RP and wrap
    clr(); MemNEXT = 1'b1;
    for (int i = 0; i < 16; i++) fifo.push_back(64'h100 + 64'(i));
    upd();
    run(40);
    chk("t3_writes", waddr.size(), 15);
    chk("t3_last_addr", waddr[14], 37'h1070);
    chk("t3_wptr", WPTR, 15);
    chk("t3_pend", PENDING, 15);
    chk("t3_left", fifo.size(), 1);
    #1;
    chk("t3_valid", VALID, 1);
    chk("t3_stall_erd", ERD, 0);
    RDPTR = 4'd4; RDPTR_WE = 1'b1;
    tick();
    RDPTR_WE = 1'b0;
    chk("t3_pend_rp", PENDING, 11);
    run(4);
    chk("t3_addr15", waddr[15], 37'h1078);
    chk("t3_data15", wdata[15], 64'h10F);
    chk("t3_wrap", WPTR, 0);
    chk("t3_pend_wrap", PENDING, 12);
    fifo.push_back(64'h200); upd();
    run(4);
    chk("t3_addr16", waddr[16], 37'h1000);
    chk("t3_wptr1", WPTR, 1);

    // Threshold interrupt and ACK priority
    do_reset(); THRESH = 4'd3;
    fifo.push_back(64'h1); fifo.push_back(64'h2); fifo.push_back(64'h3); upd();
    measure(4'd3, 12);
    chk("t4_seen", (tp >= 0 && ti >= 0), 1);
    chk("t4_lat", 32'(ti - tp), 1);
    INTR_ACK = 1'b1; tick(); INTR_ACK = 1'b0;
    chk("t4_ack_low", INTR, 0);
    chk("t4_ack_pend", PENDING, 3);
    tick();
    chk("t4_reraise", INTR, 1);

    // THRESH=0 acts as 1
    do_reset(); THRESH = 4'd0;
    fifo.push_back(64'h9); upd();
    measure(4'd1, 8);
    chk("t4_thr0_lat", 32'(ti - tp), 1);

    // Timeout interrupt
    do_reset(); THRESH = 4'd5;
    fifo.push_back(64'h7); upd();
    measure(4'd1, 16);
    chk("t5_to_lat", 32'(ti - tp), 8);
    INTR_ACK = 1'b1; RDPTR = 4'd1; RDPTR_WE = 1'b1;
    tick();
    INTR_ACK = 1'b0; RDPTR_WE = 1'b0;
    chk("t5_clr_intr", INTR, 0);
    chk("t5_clr_pend", PENDING, 0);
    fifo.push_back(64'h8); upd();
    ti = 0;
    for (int c = 0; c < 5; c++) begin tick(); if (INTR) ti = 1; end
    chk("t5_pend_pre", PENDING, 1);
    RDPTR = 4'd2; RDPTR_WE = 1'b1;
    tick(); if (INTR) ti = 1;
    RDPTR_WE = 1'b0;
    for (int c = 0; c < 12; c++) begin tick(); if (INTR) ti = 1; end
    chk("t5_no_intr", ti, 0);

    // Records arriving while full
    do_reset(); THRESH = 4'd15;
    for (int i = 0; i < 15; i++) fifo.push_back(64'h300 + 64'(i));
    upd();
    run(36);
    chk("t6_full_wptr", WPTR, 15);
    erd_cnt = 0; act_cnt = 0;
    fifo.push_back(64'hD1); fifo.push_back(64'hD2); fifo.push_back(64'hD3); upd();
    run(10);
    chk("t6_act", act_cnt, 0);
    chk("t6_wptr", WPTR, 15);
`ifdef ERRDISP_DROP_EN
    chk("t6_erd", erd_cnt, 3);
    chk("t6_drop", DROPCNT, 3);
    chk("t6_left", fifo.size(), 0);
`else
    chk("t6_erd", erd_cnt, 0);
    chk("t6_drop", DROPCNT, 0);
    chk("t6_left", fifo.size(), 3);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/error_ring_dispatcher.md
Name: error_ring_dispatcher

Overview:
- Drains the error-report FIFO (VALID/ERD/ECD, 64-bit records).
- Writes each record into a software-visible ring buffer in local memory through a single-request memory write port.
- Tracks the hardware write index and the software read index, and raises a coalesced interrupt toward the kernel core.
- Sits between the error FIFO and the memory request arbiter.

Parameters:
ADDR_W, 37, byte address width of memory port
RING_LOG2, 6, log2 of ring depth in 64-bit entries (ring holds 2^RING_LOG2-1 records)
TIMEOUT, 1024, cycles a non-empty ring may wait before a forced interrupt (must be >=1)

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  asynchronous active-low reset
ENA  in  1  dispatch enable
BASE  in  ADDR_W  ring base byte address, 8-byte aligned, low 3 bits ignored
THRESH  in  RING_LOG2  pending-count interrupt threshold
RDPTR  in  RING_LOG2  software read index
RDPTR_WE  in  1  load RDPTR into internal read index
VALID  in  1  FIFO has a record on ECD
ECD  in  64  FIFO record
ERD  out  1  FIFO pop, combinational
MemACT  out  1  memory write request
MemNEXT  in  1  memory request accepted
MemADDR  out  ADDR_W  write byte address
MemDATA  out  64  write data
WPTR  out  RING_LOG2  hardware write index
PENDING  out  RING_LOG2  records written but not consumed
INTR  out  1  interrupt request, level
INTR_ACK  in  1  interrupt clear
DROPCNT  out  16  dropped-record count (see Optional Feature)

Behaviour:
Reset values:
- ERD=0, MemACT=0, MemADDR=0, MemDATA=0, WPTR=0, PENDING=0, INTR=0, DROPCNT=0.
- Internal RP=0, timer=0, state=IDLE.
- Reset asserted mid-WRITE aborts the request immediately; no partial state survives.

Ring indices:
- FULL = ((WPTR+1) mod 2^RING_LOG2) == RP.
- PENDING = (WPTR-RP) mod 2^RING_LOG2.
- Both indices wrap naturally.

RP update:
- RDPTR_WE loads RDPTR into RP on the same edge.
- Allowed in the same cycle as a WPTR increment; both take effect, and PENDING reflects both on the next cycle.

ERD:
- ERD = (state==IDLE) & ENA & VALID & ~FULL.
- At an edge with ERD=1: ECD is captured into MemDATA, MemADDR <= {BASE[ADDR_W-1:3] + WPTR, 3'b000}, MemACT <= 1, state <= WRITE.

State WRITE:
- MemACT, MemADDR and MemDATA are held stable.
- ERD=0.
- At the edge with MemNEXT=1: MemACT <= 0, WPTR <= WPTR+1, state <= IDLE.
- Minimum of 2 cycles per record. MemNEXT outside WRITE is ignored.

ENA and BASE changes:
- ENA deasserted during WRITE: the write completes, then no further pops.
- BASE changes affect only records not yet captured.

Stall:
- With FULL, records remain in the FIFO (ERD=0) until RP advances.

Interrupt set:
- INTR is set when PENDING >= max(THRESH,1), or when PENDING!=0 and timer==TIMEOUT-1.

Timer:
- Increments each cycle while PENDING!=0 and INTR=0.
- Cleared when PENDING==0 or INTR=1.

Interrupt clear:
- INTR_ACK clears INTR.
- ACK has priority over a set condition in the same cycle; set is re-evaluated from the next cycle.

Optional Feature:
ERRDISP_DROP_EN
- Defined: when IDLE & ENA & VALID & FULL, ERD=1 and the record is discarded (no memory write, WPTR unchanged).
- DROPCNT increments, saturating at 16'hFFFF; it clears only on reset.
- Undefined: FULL stalls as above and DROPCNT is constant 0.

Test Plan:
- Reset, RING_LOG2=4, BASE=0x1000, ENA=1, one FIFO record 0xA5A5_0000_1234_5678, MemNEXT one cycle after MemACT -> single ERD pulse; MemADDR=0x1000, MemDATA=record; WPTR=1, PENDING=1 after NEXT.
- Back-to-back 3 records, MemNEXT held 1 -> MemACT high 3 separate cycles; addresses 0x1000/0x1008/0x1010; ERD never asserted while MemACT=1.
- 16 records, RP=0 -> 15 written, WPTR=15, ERD low with VALID high; RDPTR_WE with RDPTR=4 -> next record lands at 0x1078; WPTR then wraps to 0; following record lands at 0x1000.
- THRESH=3 -> INTR rises the cycle after PENDING reaches 3; INTR_ACK with PENDING still 3 -> INTR low 1 cycle, then high again.
- TIMEOUT=8, THRESH=5, one record -> INTR rises 8 cycles after PENDING becomes 1; RDPTR_WE to WPTR before expiry -> no INTR.
- Macro defined, ring full, 3 more records -> 3 ERD pulses, no MemACT, DROPCNT=3. Macro undefined -> ERD stays 0, DROPCNT=0.
